dtc_apb_splitter: RTL and testbench
===================================

DTC_APB_SPLITTER -- requirements
Module: dtc_apb_splitter

Interface
REQ-001 Parameter APB_AWIDTH, default 32, upstream and downstream address width.
REQ-002 Parameter APB_DWIDTH, default 32, data width.
REQ-003 Parameter NUM_SLV, default 4 (range 1..16), number of downstream APB slaves.
REQ-004 Parameter SLV_STRIDE, default 32'h100 (power of two), address window size per slave; slave i owns [i*SLV_STRIDE, (i+1)*SLV_STRIDE).
REQ-005 Parameter TIMEOUT_CYC, default 16 (≥2), maximum downstream access-phase cycles.
REQ-006 pclk  in  1  single clock; all logic rising-edge.
REQ-007 prst  in  1  reset, synchronous, active-high.
REQ-008 psel, penable, pwrite  in  1 each  upstream APB control.
REQ-009 paddr  in  APB_AWIDTH; pwdata  in  APB_DWIDTH  upstream address/write data.
REQ-010 pready, pslverr  out  1 each; prdata  out  APB_DWIDTH  upstream response.
REQ-011 m_psel  out  NUM_SLV  one-hot downstream select.
REQ-012 m_paddr  out  APB_AWIDTH  local offset (paddr modulo SLV_STRIDE), shared by all slaves.
REQ-013 m_penable, m_pwrite  out  1; m_pwdata  out  APB_DWIDTH  shared downstream signals.
REQ-014 m_pready, m_pslverr  in  NUM_SLV; m_prdata  in  NUM_SLV*APB_DWIDTH, slave i at bits [i*APB_DWIDTH +: APB_DWIDTH].
REQ-015 err_clr  in  1  synchronous clear of err_cnt.
REQ-016 err_cnt  out  16  saturating error counter.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, RESP; one transfer in flight.
REQ-018 IDLE: on psel=1 & penable=0, latch paddr/pwdata/pwrite and decode; a valid slave index goes to SETUP, an address ≥ NUM_SLV*SLV_STRIDE goes to RESP with decode error.
REQ-019 SETUP: m_psel[i]=1, m_penable=0, latched m_paddr/m_pwrite/m_pwdata; always goes to ACCESS next cycle.
REQ-020 ACCESS: m_psel[i]=1, m_penable=1; on m_pready[i]=1, capture m_prdata slice i (reads only, 0 for writes) and m_pslverr[i], go to RESP.
REQ-021 RESP: pready=1 for exactly one cycle with captured prdata/pslverr, all m_psel=0; then IDLE.
REQ-022 pready=0 in every state other than RESP; prdata and pslverr are 0 whenever pready=0.
REQ-023 Latency: upstream setup at cycle T; m_psel at T+1; m_penable at T+2; with zero-wait slave, pready at T+3; each slave wait state adds one cycle.
REQ-024 Decode error: pready=1, pslverr=1, prdata=0 at T+1; no downstream select asserted.
REQ-025 Timeout (when enabled): counter clears on ACCESS entry and increments each ACCESS cycle with m_pready[i]=0; on reaching TIMEOUT_CYC, go to RESP with pslverr=1, prdata=0, m_psel dropped.
REQ-026 m_pready/m_pslverr/m_prdata from unselected slaves are ignored.
REQ-027 err_cnt increments by 1 in the RESP cycle when pslverr=1; saturates at 16'hFFFF; err_clr has priority over same-cycle increment (result 0).
REQ-028 New upstream setup phases are sampled only in IDLE; psel in other states has no effect.

Reset
REQ-029 prst=1 at a clock edge forces IDLE, counters 0, err_cnt 0; all outputs 0 from the following cycle, including mid-transfer (in-flight transfer abandoned, no response).

Configuration
REQ-030 Macro DTC_APB_TIMEOUT_EN defined: timeout counter and REQ-025 behaviour compiled in.
REQ-031 Macro DTC_APB_TIMEOUT_EN undefined: no timeout logic; ACCESS waits indefinitely for m_pready[i]; TIMEOUT_CYC unused.

Verification
REQ-032 Write 0x0000_0104 data 0xA5A5_5A5A, slave 1 zero-wait -> m_psel=4'b0010, m_paddr=0x4, pready at T+3, pslverr=0.
REQ-033 Read 0x0000_0300, slave 3 waits 2 cycles, returns 0x1234_5678 -> pready at T+5, prdata=0x1234_5678.
REQ-034 Read 0x0000_0400 (NUM_SLV=4) -> pready/pslverr at T+1, prdata=0, m_psel=0, err_cnt=1.
REQ-035 DTC_APB_TIMEOUT_EN defined, slave 2 never ready -> pslverr=1 after 16 ACCESS cycles, err_cnt increments; undefined -> pready stays 0.
REQ-036 prst asserted during ACCESS -> next cycle all outputs 0, IDLE; following transfer completes normally.
REQ-037 err_cnt preset to 0xFFFF via errors, further error -> stays 0xFFFF; err_clr with simultaneous error -> 0.

Source files
------------

// File: rtl/dtc_apb_splitter.sv
// dtc_apb_splitter
//   Splits one upstream APB slave port across NUM_SLV downstream APB slaves.
//   Each slave owns an aligned window of SLV_STRIDE bytes starting at address 0.
//   Only one transfer is in flight: the upstream setup phase is latched in IDLE,
//   replayed downstream as SETUP/ACCESS, and answered upstream in a single RESP
//   cycle. Addresses past the last window are answered with a decode error.
//   A saturating 16-bit counter records every error response.
//
// Optional feature:
//   DTC_APB_TIMEOUT_EN - when defined, an ACCESS phase that has waited
//   TIMEOUT_CYC cycles is abandoned and answered with pslverr=1, prdata=0.
//   When undefined, ACCESS waits for the selected slave indefinitely.
//
// Ports:
//   pclk, prst                  clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata   upstream APB request
//   pready/pslverr/prdata       upstream APB response (zero unless pready)
//   m_psel[NUM_SLV]             one-hot downstream select
//   m_penable/m_pwrite/m_paddr/m_pwdata   shared downstream request
//                               (m_paddr is the offset inside the window)
//   m_pready/m_pslverr/m_prdata per-slave downstream responses
//   err_clr, err_cnt            error counter clear / value
module dtc_apb_splitter #(
  parameter int APB_AWIDTH  = 32,
  parameter int APB_DWIDTH  = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_STRIDE  = 32'h100,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          pclk,
  input  logic                          prst,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [APB_AWIDTH-1:0]         paddr,
  input  logic [APB_DWIDTH-1:0]         pwdata,
  output logic                          pready,
  output logic                          pslverr,
  output logic [APB_DWIDTH-1:0]         prdata,
  output logic [NUM_SLV-1:0]            m_psel,
  output logic [APB_AWIDTH-1:0]         m_paddr,
  output logic                          m_penable,
  output logic                          m_pwrite,
  output logic [APB_DWIDTH-1:0]         m_pwdata,
  input  logic [NUM_SLV-1:0]            m_pready,
  input  logic [NUM_SLV-1:0]            m_pslverr,
  input  logic [NUM_SLV*APB_DWIDTH-1:0] m_prdata,
  input  logic                          err_clr,
  output logic [15:0]                   err_cnt
);

  localparam int SHIFT = $clog2(SLV_STRIDE);
  localparam int IDXW  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [APB_AWIDTH-1:0] OFF_MASK  = APB_AWIDTH'(SLV_STRIDE - 1);
  localparam logic [APB_AWIDTH-1:0] NUM_SLV_A = APB_AWIDTH'(NUM_SLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [APB_AWIDTH-1:0]   addr_q, addr_d;
  logic [APB_DWIDTH-1:0]   wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic [APB_DWIDTH-1:0]   rdata_q, rdata_d;
  logic                    slverr_q, slverr_d;
  logic [15:0]             err_cnt_q, err_cnt_d;

  // Window number of the incoming address; anything at or above NUM_SLV
  // falls outside every slave window.
  logic [APB_AWIDTH-1:0]   addr_slot;
  logic                    dec_hit;
  assign addr_slot = paddr >> SHIFT;
  assign dec_hit   = (addr_slot < NUM_SLV_A);

  // Response of the selected slave only; the others are masked to zero so
  // their handshakes and data can never leak into the upstream response.
  logic [NUM_SLV-1:0]      slv_oh;
  logic [APB_DWIDTH-1:0]   rdata_masked [NUM_SLV];
  logic [APB_DWIDTH-1:0]   sel_rdata;
  logic                    sel_ready;
  logic                    sel_slverr;

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
    assign slv_oh[gi]       = (idx_q == IDXW'(gi));
    assign rdata_masked[gi] = slv_oh[gi] ? m_prdata[gi*APB_DWIDTH +: APB_DWIDTH] : '0;
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_rdata = sel_rdata | rdata_masked[i];
    end
  end

  assign sel_ready  = |(m_pready & slv_oh);
  assign sel_slverr = |(m_pslverr & slv_oh);

`ifdef DTC_APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 1);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
`ifdef DTC_APB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d   = paddr & OFF_MASK;
          wdata_d  = pwdata;
          write_d  = pwrite;
          rdata_d  = '0;
          slverr_d = 1'b0;
          if (dec_hit) begin
            idx_d   = addr_slot[IDXW-1:0];
            state_d = SETUP;
          end else begin
            slverr_d = 1'b1;
            state_d  = RESP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef DTC_APB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d  = write_q ? '0 : sel_rdata;
          slverr_d = sel_slverr;
          state_d  = RESP;
        end
`ifdef DTC_APB_TIMEOUT_EN
        // This is the TIMEOUT_CYC-th cycle without a ready: give up.
        else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          rdata_d  = '0;
          slverr_d = 1'b1;
          state_d  = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over a same-cycle error increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (state_q == RESP && slverr_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      err_cnt_q <= '0;
`ifdef DTC_APB_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      err_cnt_q <= err_cnt_d;
`ifdef DTC_APB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // Downstream request is driven only while a slave is selected.
  logic xfer_sel;
  assign xfer_sel  = (state_q == SETUP) || (state_q == ACCESS);
  assign m_psel    = xfer_sel ? slv_oh : '0;
  assign m_penable = (state_q == ACCESS);
  assign m_paddr   = xfer_sel ? addr_q : '0;
  assign m_pwrite  = xfer_sel ? write_q : 1'b0;
  assign m_pwdata  = xfer_sel ? wdata_q : '0;

  assign pready  = (state_q == RESP);
  assign prdata  = pready ? rdata_q : '0;
  assign pslverr = pready ? slverr_q : 1'b0;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_dtc_apb_splitter.sv
// Self-checking bench for dtc_apb_splitter: directed boundary cases followed
// by randomized transfers. Expected responses come from a transaction-level
// model (window arithmetic + a word array per slave) and are queued at issue
// time; a monitor pops and compares whenever pready is seen.
module tb_dtc_apb_splitter;
  localparam int AW = 32, DW = 32, NS = 4, STRIDE = 256, TMO = 16;
  localparam int NEVER = 1000;

  logic pclk = 1'b0, prst = 1'b1;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic pready, pslverr;
  logic [DW-1:0] prdata;
  logic [NS-1:0] m_psel, m_pready, m_pslverr;
  logic [AW-1:0] m_paddr;
  logic m_penable, m_pwrite;
  logic [DW-1:0] m_pwdata;
  logic [NS*DW-1:0] m_prdata;
  logic [15:0] err_cnt;

  dtc_apb_splitter #(.APB_AWIDTH(AW), .APB_DWIDTH(DW), .NUM_SLV(NS),
                     .SLV_STRIDE(STRIDE), .TIMEOUT_CYC(TMO)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
    .prdata(prdata), .m_psel(m_psel), .m_paddr(m_paddr), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pready(m_pready),
    .m_pslverr(m_pslverr), .m_prdata(m_prdata), .err_clr(err_clr), .err_cnt(err_cnt));

  always #5 pclk = ~pclk;

  int compared = 0, mismatched = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- downstream slave environment ----------------
  int wait_cfg [NS];
  logic slverr_cfg [NS];
  int wcnt [NS];
  logic [31:0] slave_mem [NS][64];
  logic mem_init = 1'b0;
  logic [NS-1:0] noise_rdy = '0, noise_err = '0;
  logic [NS*DW-1:0] noise_data = '0;

  function automatic logic [31:0] pat(input int s, input int w);
    if (s == 3 && w == 0) return 32'h1234_5678;
    return {8'(s), 8'(w), 16'hC0DE};
  endfunction

  // Unselected slaves present random handshakes/data to prove they are ignored.
  for (genvar gi = 0; gi < NS; gi++) begin : g_slave
    logic acc;
    assign acc = m_psel[gi] & m_penable;
    assign m_pready[gi]  = acc ? (wcnt[gi] == wait_cfg[gi]) : noise_rdy[gi];
    assign m_pslverr[gi] = acc ? slverr_cfg[gi] : noise_err[gi];
    assign m_prdata[gi*DW +: DW] = acc ? slave_mem[gi][m_paddr[7:2]] : noise_data[gi*DW +: DW];
  end

  always @(posedge pclk) begin
    noise_rdy  <= NS'($urandom);
    noise_err  <= NS'($urandom);
    noise_data <= {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NS; i++) begin
      if (!mem_init) begin
        for (int w = 0; w < 64; w++) slave_mem[i][w] <= pat(i, w);
      end
      if (m_psel[i] && m_penable) begin
        if (wcnt[i] == wait_cfg[i]) begin
          if (m_pwrite && mem_init) slave_mem[i][m_paddr[7:2]] <= m_pwdata;
          wcnt[i] <= 0;
        end else begin
          wcnt[i] <= wcnt[i] + 1;
        end
      end else begin
        wcnt[i] <= 0;
      end
    end
    mem_init <= 1'b1;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  logic [31:0] model_mem [NS][64];
  logic [15:0] model_err = '0;

  function automatic exp_t predict(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
    exp_t e;
    int slot, word;
    slot = int'(addr / STRIDE);
    word = int'((addr % STRIDE) / 4);
    e.issue = cyc;
    e.rdata = '0;
    e.slverr = 1'b1;
    e.lat = 1;
    if (slot >= NS) return e;
    if (wait_cfg[slot] == NEVER) begin
      e.lat = 2 + TMO;
      return e;
    end
    e.lat = 3 + wait_cfg[slot];
    e.slverr = slverr_cfg[slot];
    if (wr) model_mem[slot][word] = wdata;
    else    e.rdata = model_mem[slot][word];
    return e;
  endfunction

  // Monitor: compares every upstream response against the queue head.
  initial begin
    exp_t e;
    logic exp_err;
    forever begin
      @(negedge pclk);
      exp_err = 1'b0;
      if (prst) begin
        model_err = '0;
      end else begin
        if (pready) begin
          if (sb.size() == 0) begin
            chk("unexpected_pready", 64'(pready), 64'(0));
          end else begin
            e = sb.pop_front();
            $display("resp: issue=%0d lat=%0d prdata=0x%08h pslverr=%0d err_cnt=%0d",
                     e.issue, cyc - e.issue, prdata, pslverr, err_cnt);
            chk("resp_prdata", 64'(prdata), 64'(e.rdata));
            chk("resp_pslverr", 64'(pslverr), 64'(e.slverr));
            chk("resp_latency", 64'(cyc - e.issue), 64'(e.lat));
            chk("resp_msel_zero", 64'(m_psel), 64'(0));
            chk("resp_err_cnt", 64'(err_cnt), 64'(model_err));
            exp_err = e.slverr;
          end
        end else begin
          chk("idle_resp_zero", 64'({prdata, pslverr}), 64'(0));
        end
        if (err_clr) model_err = '0;
        else if (exp_err && model_err != 16'hFFFF) model_err = model_err + 16'd1;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr, input logic clr);
    exp_t e;
    logic got;
    int slot;
    slot = int'(addr / STRIDE);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwdata = wdata; pwrite = wr; err_clr = clr;
    e = predict(addr, wdata, wr);
    sb.push_back(e);
    @(posedge pclk); #1;
    penable = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge pclk);
      if (n == 0 && slot < NS) begin
        chk("setup_msel", 64'(m_psel), 64'(1 << slot));
        chk("setup_menable", 64'(m_penable), 64'(0));
        chk("setup_maddr", 64'(m_paddr), 64'(addr % STRIDE));
        chk("setup_mwrite", 64'(m_pwrite), 64'(wr));
        chk("setup_mwdata", 64'(m_pwdata), wr ? 64'(wdata) : 64'(wdata));
      end
      got = pready;
    end
    if (!got) chk("xfer_no_pready", 64'(got), 64'(1));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; err_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge pclk); #1;
    prst = 1'b1; psel = 1'b0; penable = 1'b0;
    sb.delete();
    @(posedge pclk); #1;
    prst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"}, 64'(pready), 64'(0));
    chk({tag, "_prdata_pslverr"}, 64'({prdata, pslverr}), 64'(0));
    chk({tag, "_msel_men_mwr"}, 64'({m_psel, m_penable, m_pwrite}), 64'(0));
    chk({tag, "_maddr_mwdata"}, 64'({m_paddr, m_pwdata}), 64'(0));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < NS; s++) begin
      wait_cfg[s] = 0;
      slverr_cfg[s] = 1'b0;
      wcnt[s] = 0;
      for (int w = 0; w < 64; w++) model_mem[s][w] = pat(s, w);
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk_all_zero("reset");
    @(posedge pclk); #1;
    prst = 1'b0;

    // Zero-wait write to slave 1.
    wait_cfg[1] = 0;
    do_xfer(32'h0000_0104, 32'hA5A5_5A5A, 1'b1, 1'b0);
    // Read from slave 3 with two wait states.
    wait_cfg[3] = 2;
    do_xfer(32'h0000_0300, 32'h0, 1'b0, 1'b0);
    // Decode error.
    do_xfer(32'h0000_0400, 32'h0, 1'b0, 1'b0);
    @(negedge pclk);
    chk("err_cnt_after_decode", 64'(err_cnt), 64'(1));

    // Slave 2 never answers.
    wait_cfg[2] = NEVER;
`ifdef DTC_APB_TIMEOUT_EN
    do_xfer(32'h0000_0208, 32'h0, 1'b0, 1'b0);
    @(negedge pclk);
    chk("err_cnt_after_timeout", 64'(err_cnt), 64'(2));
`else
    begin
      int hits;
      hits = 0;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0208; pwrite = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      repeat (40) begin
        @(negedge pclk);
        if (pready) hits++;
      end
      chk("hang_no_pready", 64'(hits), 64'(0));
      chk("hang_still_access", 64'({m_psel, m_penable}), 64'({4'b0100, 1'b1}));
      pulse_reset();
    end
`endif

    // Reset in the middle of an ACCESS phase.
    wait_cfg[2] = 5;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0210; pwrite = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("mid_in_access", 64'({m_psel, m_penable}), 64'({4'b0100, 1'b1}));
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk_all_zero("mid_reset");
    wait_cfg[2] = 1;
    do_xfer(32'h0000_02F0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic; few word offsets so reads often hit earlier writes.
    for (int n = 0; n < 60; n++) begin
      int slot, word;
      logic wr;
      logic [31:0] data;
      for (int s = 0; s < NS; s++) begin
        wait_cfg[s] = $urandom_range(0, 3);
        slverr_cfg[s] = ($urandom_range(0, 7) == 0);
      end
      slot = $urandom_range(0, 5);
      word = $urandom_range(0, 7);
      wr = 1'($urandom_range(0, 1));
      data = $urandom;
      do_xfer(32'(slot * STRIDE + word * 4), data, wr, 1'b0);
    end

    // Saturation and clear priority.
    force dut.err_cnt_q = 16'hFFFE;
    model_err = 16'hFFFE;
    @(posedge pclk); #1;
    release dut.err_cnt_q;
    do_xfer(32'h0000_0500, 32'h0, 1'b0, 1'b0);
    @(negedge pclk);
    chk("err_cnt_reach_max", 64'(err_cnt), 64'(16'hFFFF));
    do_xfer(32'h0000_0400, 32'h0, 1'b0, 1'b0);
    @(negedge pclk);
    chk("err_cnt_saturate", 64'(err_cnt), 64'(16'hFFFF));
    do_xfer(32'h0000_07FC, 32'h0, 1'b0, 1'b1);
    @(negedge pclk);
    chk("err_clr_priority", 64'(err_cnt), 64'(0));

    repeat (2) @(negedge pclk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
